// File: rtl/nspi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nspi_pkg
// Purpose  : Shared types and default constants for the N-channel SPI path.
// Revision : 1.0 - initial release
// ============================================================================
package nspi_pkg;

   // Default channel count (one matrix per channel)
   localparam int NSPI_CHANNELS      = 3;
   // Default word width per channel
   localparam int NSPI_WORD          = 8;
   // 16x8 RGB matrix frame size in bytes
   localparam int MATRIX_FRAME_BYTES = 384;

   // Frame feeder control states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } feeder_state_t;

   // Larger of two integers, used for shared timer sizing
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nspi_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : nspi_frame_feeder
// Purpose  : Feeds one word per channel into nspi_tx, tracks frame alignment,
//            retries unacknowledged starts and inserts an idle gap after each
//            frame so the matrix controllers can find the frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module nspi_frame_feeder
   import nspi_pkg::*;
#(
   parameter int CHANNEL_NUMBER = NSPI_CHANNELS,
   parameter int SPI_SIZE       = NSPI_WORD,
   parameter int FRAME_BYTES    = MATRIX_FRAME_BYTES,
   parameter int GAP_CYCLES     = 64,
   parameter int ACK_TIMEOUT    = 8
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     in_sof,
   input  logic [SPI_SIZE-1:0][CHANNEL_NUMBER-1:0]  in_data,
   output logic [SPI_SIZE-1:0][CHANNEL_NUMBER-1:0]  tx_data,
   output logic                                     start_tx,
   input  logic                                     tx_finish,
   output logic                                     frame_done,
   output logic                                     sof_error,
   output logic                                     ack_error
);

   // A one-word frame still needs a 1-bit counter
   localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   // One timer serves both the ack timeout and the frame gap
   localparam int TMR_W = $clog2(max_int(GAP_CYCLES, ACK_TIMEOUT) + 1);

   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(FRAME_BYTES - 1);
   localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   feeder_state_t    state;
   feeder_state_t    state_next;
   logic             in_frame;
   logic [CNT_W-1:0] byte_cnt;
   logic [TMR_W-1:0] tmr;

   // Decoded events for this cycle
   logic             load;
   logic             sof_start;
   logic             ack_to;
   logic             last_done;
   logic             word_done;

   // State register; reset forces IDLE at once so start_tx drops immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and combinational handshake outputs
   always_comb begin
      state_next = state;
      load       = 1'b0;
      sof_start  = 1'b0;
      ack_to     = 1'b0;
      last_done  = 1'b0;
      word_done  = 1'b0;
      in_ready   = (state == IDLE) && !rst;
      start_tx   = (state == START);
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_sof) begin
                  load       = 1'b1;
                  sof_start  = 1'b1;
                  state_next = START;
               end else if (in_frame) begin
                  load       = 1'b1;
                  state_next = START;
               end
               // a non-sof word outside a frame is dropped to resync
            end
         end
         START: begin
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (!tx_finish) begin
               state_next = WAIT_DONE;
            end else if (tmr == ACK_LAST) begin
               ack_to     = 1'b1;
               state_next = START;
            end
         end
         WAIT_DONE: begin
            // only a high sample ends the transfer; no timeout here
            if (tx_finish) begin
               if (byte_cnt == BYTE_LAST) begin
                  last_done  = 1'b1;
                  state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  word_done  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         GAP: begin
            if (tmr == GAP_LAST) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Data path, frame tracking, shared timer and registered status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data    <= '0;
         in_frame   <= 1'b0;
         byte_cnt   <= '0;
         tmr        <= '0;
         frame_done <= 1'b0;
         sof_error  <= 1'b0;
         ack_error  <= 1'b0;
      end else begin
         frame_done <= last_done;
         sof_error  <= sof_start && in_frame;
         ack_error  <= ack_to;

         if (load) begin
            tx_data <= in_data;
         end

         if (sof_start) begin
            in_frame <= 1'b1;
            byte_cnt <= '0;
         end else if (last_done) begin
            in_frame <= 1'b0;
            byte_cnt <= '0;
         end else if (word_done) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
         end

         if (state == START || last_done) begin
            tmr <= '0;
         end else if ((state == WAIT_ACK && tx_finish) || state == GAP) begin
            tmr <= tmr + TMR_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/nspi_frame_feeder.md
# nspi_frame_feeder

Upstream stage of the N-channel SPI transmitter (`nspi_tx`). It accepts one word per channel per handshake from the frame stream and tracks frame alignment. It drives `tx_data`/`start_tx` and paces each word against `tx_finish`. After the last word of a frame it inserts an idle latch gap, so the CH32V003 matrix controllers can detect the frame boundary.

## Interface
- `CHANNEL_NUMBER`, 3: number of parallel SPI channels (one matrix each).
- `SPI_SIZE`, 8: word width per channel; must equal downstream `SPI_SIZE`.
- `FRAME_BYTES`, 384: words per frame per channel (16x8 RGB); ≥1.
- `GAP_CYCLES`, 64: idle clk cycles after each frame; ≥0.
- `ACK_TIMEOUT`, 8: cycles to wait for `tx_finish` to fall after `start_tx`; ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: feeder accepts a word when `in_valid & in_ready`.
- `in_sof` in 1: qualifies the accepted word as word 0 of a frame.
- `in_data` in `[SPI_SIZE-1:0] [CHANNEL_NUMBER-1:0]`: one word per channel.
- `tx_data` out `[SPI_SIZE-1:0] [CHANNEL_NUMBER-1:0]`: to `nspi_tx.data_in`.
- `start_tx` out 1: one-cycle start pulse to `nspi_tx`.
- `tx_finish` in 1: from `nspi_tx`; low while transmitting. Sampled on `clk`.
- `frame_done` out 1: one-cycle pulse when the last word of a frame completes.
- `sof_error` out 1: one-cycle pulse when `in_sof` arrives mid-frame.
- `ack_error` out 1: one-cycle pulse on ack timeout.

## Operation
- States: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
- Internal registers: `in_frame` flag, `byte_cnt` (width `$clog2(FRAME_BYTES)`), `tmr` (width `$clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1)`).
- Reset values:
  - State IDLE.
  - `tx_data` = 0.
  - `start_tx`, `frame_done`, `sof_error`, `ack_error` = 0.
  - `in_frame` = 0, `byte_cnt` = 0.
  - `in_ready` = 0 while `rst` is high.
- `in_ready` = 1 only in IDLE (combinational from state).
- Accept in IDLE:
  - `in_sof` = 1: load `tx_data`, set `byte_cnt` = 0, set `in_frame` = 1, go to START. Pulse `sof_error` if `in_frame` was already 1 (the partial frame is abandoned).
  - `in_sof` = 0 and `in_frame` = 1: load `tx_data`, go to START.
  - `in_sof` = 0 and `in_frame` = 0: discard the word and stay in IDLE (resync).
- START: `start_tx` = 1 for this cycle only; clear `tmr`; go to WAIT_ACK.
- WAIT_ACK:
  - `tx_finish` = 0: go to WAIT_DONE.
  - Otherwise `tmr++`. When `tmr == ACK_TIMEOUT-1`, pulse `ack_error` and return to START (retry the same word).
- WAIT_DONE: on `tx_finish` = 1:
  - If `byte_cnt == FRAME_BYTES-1`: pulse `frame_done`, clear `in_frame` and `byte_cnt`, clear `tmr`, go to GAP. If `GAP_CYCLES` = 0, go to IDLE instead.
  - Otherwise `byte_cnt++` and go to IDLE.
- GAP: `tmr++`; at `tmr == GAP_CYCLES-1` go to IDLE. `in_ready` stays 0 throughout.
- `tx_data` changes only on accept, so it is stable from START through WAIT_DONE.
- WAIT_DONE has no timeout; `nspi_tx` always completes.

## Timing
- Accept at edge N → `start_tx` high in cycle N+1 → earliest WAIT_DONE exit in cycle N+3.
- Next `in_ready` comes the cycle after `tx_finish` is seen high, giving per-word overhead of 2 cycles plus the `nspi_tx` transfer time.
- Frame period ≥ FRAME_BYTES × (word time) + `GAP_CYCLES`.
- Error and done pulses are exactly 1 cycle wide and registered.
- Reset asserted mid-transfer forces IDLE immediately; `start_tx` drops asynchronously. `nspi_tx` shares `rst`.
- Simultaneous events:
  - `in_sof` accepted while `in_frame` = 1: `sof_error` and the new frame start occur in the same cycle.
  - A `tx_finish` glitch low in WAIT_DONE is ignored; exit is on a high sample only.

## Structure
- Shared package `nspi_pkg` holds:
  - `feeder_state_t` enum (IDLE, START, WAIT_ACK, WAIT_DONE, GAP).
  - Default constants `NSPI_CHANNELS` = 3, `NSPI_WORD` = 8, `MATRIX_FRAME_BYTES` = 384.
- No sub-module; one FSM plus counters. The bench instantiates `nspi_frame_feeder` → `nspi_tx` together, plus a standalone variant with a modelled `tx_finish`.

## Test plan
- **Reset:** hold `rst` 3 cycles. Expect all outputs 0 and `in_ready` = 0; `in_ready` = 1 the first cycle after release.
- **Full frame:** `FRAME_BYTES` = 4, `GAP_CYCLES` = 5, words 0xA1..0xA4 with `in_sof` on the first.
  - Expect 4 `start_tx` pulses and `tx_data` matching each word.
  - Expect `frame_done` once after the 4th `tx_finish` rise.
  - Expect `in_ready` low for exactly 5 cycles afterwards.
- **Resync:** send 3 words without `in_sof`, then an sof word 0x55. Expect the first 3 discarded with no `start_tx`, and the first `start_tx` carrying 0x55.
- **Mid-frame sof:** `in_sof` on word 2 of 4. Expect a `sof_error` pulse, `byte_cnt` restarted, and `frame_done` only after 4 further words.
- **Ack timeout:** `tx_finish` stuck high with `ACK_TIMEOUT` = 8. Expect `ack_error` every 9 cycles and `start_tx` re-pulsed with unchanged `tx_data`. Release `tx_finish` and expect normal completion.
- **Reset mid-frame:** assert `rst` in WAIT_DONE of word 2. Expect IDLE, then the next non-sof word discarded.
